// File: rtl/uart_pkg.sv
// Shared types and constants for the AXI-Stream UART transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 8;
  localparam int TIMER_W    = 19;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Bit period minus one in clocks; a prescale of 0 runs as 1.
  function automatic logic [TIMER_W-1:0] bit_period_m1(input logic [15:0] prescale);
    logic [TIMER_W-1:0] p;
    p = (prescale == 16'd0) ? TIMER_W'(1) : TIMER_W'(prescale);
    return p * TIMER_W'(OVERSAMPLE) - TIMER_W'(1);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter; zero flags the last clock of a bit.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TIMER_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_axis.sv
// AXI-Stream to UART transmitter: start bit, DATA_WIDTH bits LSB first, stop bit.
// Build option UART_TX_PARITY_EN adds a parity bit and the parity_odd input.
//
// state  | meaning
// IDLE   | line high, tready high, waiting for a handshake
// START  | driving the start bit (0)
// DATA   | shifting data bits out LSB first
// PARITY | driving the parity bit (parity build only)
// STOP   | driving the stop bit (1)
module uart_tx_axis
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
`ifdef UART_TX_PARITY_EN
  input  logic                  parity_odd,
`endif
  input  logic [15:0]           prescale
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  uart_state_e           state_q, state_nxt;
  logic                  txd_q, txd_nxt;
  logic                  busy_q, busy_nxt;
  logic                  tready_q, tready_nxt;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_nxt;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_nxt;
  logic [15:0]           pre_q, pre_nxt;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_nxt;
`endif

  logic                  timer_load;
  logic [TIMER_W-1:0]    timer_val;
  logic                  timer_zero;

  uart_bit_timer u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      tready_q  <= 1'b0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      pre_q     <= '0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_nxt;
      txd_q     <= txd_nxt;
      busy_q    <= busy_nxt;
      tready_q  <= tready_nxt;
      shreg_q   <= shreg_nxt;
      bit_cnt_q <= bit_cnt_nxt;
      pre_q     <= pre_nxt;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state_q;
    txd_nxt     = txd_q;
    busy_nxt    = busy_q;
    tready_nxt  = tready_q;
    shreg_nxt   = shreg_q;
    bit_cnt_nxt = bit_cnt_q;
    pre_nxt     = pre_q;
`ifdef UART_TX_PARITY_EN
    par_nxt     = par_q;
`endif
    timer_load  = 1'b0;
    timer_val   = bit_period_m1(pre_q);

    case (state_q)
      IDLE: begin
        txd_nxt    = 1'b1;
        busy_nxt   = 1'b0;
        tready_nxt = 1'b1;
        // tready_q gates the handshake, so the edge leaving reset only raises tready.
        if (s_axis_tvalid && tready_q) begin
          shreg_nxt   = s_axis_tdata;
          pre_nxt     = prescale;
          bit_cnt_nxt = CNT_W'(DATA_WIDTH);
          timer_load  = 1'b1;
          timer_val   = bit_period_m1(prescale);
          txd_nxt     = 1'b0;
          busy_nxt    = 1'b1;
          tready_nxt  = 1'b0;
          state_nxt   = START;
`ifdef UART_TX_PARITY_EN
          par_nxt     = (^s_axis_tdata) ^ parity_odd;
`endif
        end
      end

      START: begin
        if (timer_zero) begin
          txd_nxt     = shreg_q[0];
          shreg_nxt   = shreg_q >> 1;
          bit_cnt_nxt = bit_cnt_q - 1'b1;
          timer_load  = 1'b1;
          state_nxt   = DATA;
        end
      end

      DATA: begin
        if (timer_zero) begin
          timer_load = 1'b1;
          if (bit_cnt_q == '0) begin
`ifdef UART_TX_PARITY_EN
            txd_nxt   = par_q;
            state_nxt = PARITY;
`else
            txd_nxt   = 1'b1;
            state_nxt = STOP;
`endif
          end else begin
            txd_nxt     = shreg_q[0];
            shreg_nxt   = shreg_q >> 1;
            bit_cnt_nxt = bit_cnt_q - 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (timer_zero) begin
          txd_nxt    = 1'b1;
          timer_load = 1'b1;
          state_nxt  = STOP;
        end
      end
`endif

      STOP: begin
        if (timer_zero) begin
          txd_nxt    = 1'b1;
          busy_nxt   = 1'b0;
          tready_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end

      default: begin
        txd_nxt    = 1'b1;
        busy_nxt   = 1'b0;
        tready_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  assign s_axis_tready = tready_q;
  assign txd           = txd_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_axis.sv
// Randomized self-checking bench for uart_tx_axis against a frame-level line model.
module tb_uart_tx_axis;

  logic        clk;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        txd;
  logic        busy;
  logic [15:0] prescale;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hs_cyc   = 0;
  int last_dur = 0;

  uart_tx_axis #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .txd           (txd),
    .busy          (busy),
`ifdef UART_TX_PARITY_EN
    .parity_odd    (1'b0),
`endif
    .prescale      (prescale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sends one word and checks the whole line waveform against the frame model:
  // 10 bits (start, data LSB first, stop), each 8*max(p,1) clocks.
  // During the frame tdata is scrambled and prescale set to p_mid; tvalid stays high when hold=1.
  task automatic do_frame(input logic [7:0] d, input logic [15:0] p,
                          input logic [15:0] p_mid, input bit hold);
    int dur, busy_cnt, rdy_cnt, w, b;
    int match[10];
    bit exp_bits[10];
    dur = 8 * ((p == 16'd0) ? 1 : int'(p));
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = bit'((d >> i) & 8'd1);
    exp_bits[9] = 1'b1;
    for (int i = 0; i < 10; i++) match[i] = 0;
    busy_cnt = 0;
    rdy_cnt  = 0;
    w = 0;
    while (s_axis_tready !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (s_axis_tready !== 1'b1) begin
      chk_val("ready_wait", 32'(s_axis_tready), 32'd1);
      return;
    end
    s_axis_tdata  = d;
    prescale      = p;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1 hs_cyc = cyc;
    last_dur = dur;
    for (int k = 0; k < 10 * dur; k++) begin
      @(negedge clk);
      if (k == 0) begin
        s_axis_tvalid = hold;
        s_axis_tdata  = 8'($urandom);
        prescale      = p_mid;
      end
      b = k / dur;
      if (txd === exp_bits[b]) match[b]++;
      if (busy === 1'b1) busy_cnt++;
      if (s_axis_tready === 1'b1) rdy_cnt++;
    end
    for (int i = 0; i < 10; i++)
      chk_val($sformatf("bit%0d_d%02h_p%0d", i, d, p), 32'(match[i]), 32'(dur));
    chk_val("busy_len", 32'(busy_cnt), 32'(10 * dur));
    chk_val("ready_in_frame", 32'(rdy_cnt), 32'd0);
    @(negedge clk);
    chk_val("end_idle", {29'd0, busy, s_axis_tready, txd}, 32'b011);
  endtask

  initial begin
    int bad, pc, pd;
    bit ph, hold;
    logic [7:0] d;
    logic [15:0] p;

    rst           = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'hC3;
    prescale      = 16'd1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (txd !== 1'b1 || s_axis_tready !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk_val("rst_hold", 32'(bad), 32'd0);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    #1 chk_val("rst_rel_rdy0", 32'(s_axis_tready), 32'd0);
    @(negedge clk);
    chk_val("rst_rel_rdy1", 32'(s_axis_tready), 32'd1);
    chk_val("idle_txd", 32'(txd), 32'd1);

    do_frame(8'h5A, 16'd1, 16'd1, 1'b0);

    do_frame(8'h00, 16'd2, 16'd2, 1'b1);
    pc = hs_cyc;
    do_frame(8'hFF, 16'd2, 16'd2, 1'b0);
    chk_val("b2b_spacing", 32'(hs_cyc - pc), 32'd161);

    do_frame(8'h3C, 16'd1, 16'd4, 1'b0);
    do_frame(8'hC6, 16'd4, 16'd4, 1'b0);

    do_frame(8'h01, 16'd0, 16'd0, 1'b0);

    ph = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d    = 8'($urandom);
      p    = 16'($urandom_range(0, 3));
      hold = (i < 5) ? bit'($urandom_range(0, 1)) : 1'b0;
      pc = hs_cyc;
      pd = last_dur;
      do_frame(d, p, 16'($urandom_range(0, 5)), hold);
      if (ph) chk_val("rand_spacing", 32'(hs_cyc - pc), 32'(10 * pd + 1));
      ph = hold;
    end

    // Abort a frame during data bit 3 and confirm a clean restart.
    while (s_axis_tready !== 1'b1) @(negedge clk);
    s_axis_tdata  = 8'h00;
    prescale      = 16'd1;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    repeat (35) @(negedge clk);
    chk_val("pre_rst_txd", 32'(txd), 32'd0);
    #2 rst = 1'b0;
    #1 chk_val("rst_async_txd", 32'(txd), 32'd1);
    chk_val("rst_async_busy", 32'(busy), 32'd0);
    chk_val("rst_async_rdy", 32'(s_axis_tready), 32'd0);
    s_axis_tvalid = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (txd !== 1'b1 || s_axis_tready !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk_val("rst_mid_hold", 32'(bad), 32'd0);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_val("rst_mid_rdy1", 32'(s_axis_tready), 32'd1);
    do_frame(8'hA5, 16'd1, 16'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_axis.md
Name: uart_tx_axis

Overview:
- AXI-Stream-to-serial UART transmitter.
- Accepts one DATA_WIDTH-bit word per handshake and sends it on txd as a standard asynchronous frame: start bit, data bits LSB first, one stop bit.
- Bit timing comes from a runtime prescale input.
- Sits between a byte-stream producer (FIFO or CPU bridge) and the UART pin.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset); deassert is synchronised externally.
- s_axis_tdata  input  DATA_WIDTH  word to transmit.
- s_axis_tvalid  input  1  tdata valid.
- s_axis_tready  output  1  block can accept a word this cycle.
- txd  output  1  serial line; idle high.
- busy  output  1  frame in progress.
- prescale  input  16  bit period in units of 8 clocks; one bit lasts prescale*8 clk cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - txd=1, s_axis_tready=0, busy=0.
  - Counters cleared, state IDLE.
  - First cycle after release: tready rises to 1.
- States: IDLE, START, DATA, STOP (PARITY when the optional feature is enabled).
- IDLE:
  - txd=1, busy=0, tready=1.
  - Handshake when tvalid & tready on a rising edge. On that edge:
    - latch tdata into the shift register;
    - latch prescale;
    - load the bit timer with prescale*8-1;
    - txd<=0, busy<=1, tready<=0;
    - go to START.
- Bit timer:
  - 19-bit down-counter.
  - prescale is latched once per frame; changes mid-frame have no effect.
  - prescale=0 is treated as 1, i.e. 8 clocks per bit.
- Bit advance: when the timer reaches 0 at the end of a bit, the next bit is driven on the following edge and the timer is reloaded.
- START: txd=0 for 8*P clocks, then DATA.
- DATA:
  - DATA_WIDTH bits, each 8*P clocks, LSB first.
  - Shift register shifts right by one per bit.
  - Bit counter counts DATA_WIDTH down to 0.
- STOP:
  - txd=1 for 8*P clocks, then IDLE.
  - busy falls and tready rises on the same edge that enters IDLE.
- Throughput:
  - Start of frame N+1 can be accepted on the first IDLE cycle.
  - Minimum handshake-to-handshake spacing = (DATA_WIDTH+2)*8*P + 1 clocks.
- Handshake rules:
  - tready is never asserted while busy=1.
  - tvalid held high with tready low is ignored without side effects.
  - tdata is sampled only on the handshake edge.
- txd is registered and glitch-free; it changes only at bit boundaries.
- Reset mid-frame: txd returns to 1 immediately and the frame is aborted; no partial-frame resume.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - adds input parity_odd (1 bit; 0 = even, 1 = odd), latched with the frame;
  - a PARITY state between DATA and STOP drives the XOR of the data bits (inverted when odd) for 8*P clocks;
  - frame is DATA_WIDTH+3 bits.
- Undefined: no parity_odd port, no PARITY state, frame is DATA_WIDTH+2 bits.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constant OVERSAMPLE=8;
  - constant TIMER_W=19.
- Sub-module uart_bit_timer: loadable down-counter with a zero flag.
- Shift/state logic stays in the top level.

Test Plan:
- Reset:
  - hold rst=0 with tvalid=1: txd=1, tready=0, busy=0 throughout;
  - release: tready=1 the next cycle.
- Single byte, prescale=1, tdata=0x5A:
  - txd sequence 0,0,1,0,1,1,0,1,0,1, each bit exactly 8 clocks;
  - busy high for 80 clocks;
  - tready low until frame end.
- Back-to-back bytes, prescale=2, 0x00 then 0xFF with tvalid held:
  - second start bit begins 161 clocks after the first handshake;
  - each bit 16 clocks.
- prescale changed from 1 to 4 mid-frame: current frame keeps 8-clock bits; next frame uses 32-clock bits.
- prescale=0, tdata=0x01: behaves as prescale=1 (8-clock bits, LSB=1 first after start).
- Reset mid-frame after 3 data bits: txd=1 asynchronously; after release, a new byte 0xA5 transmits correctly.
